hawk_compdecomp_arb: RTL
========================

Name: hawk_compdecomp_arb

Overview:
- Parametrised, N-way arbiter/router that generalises the fixed compressor/decompressor/migrator mux in the HACD compression path.
- Accepts operation requests from the HAWK control FSM and grants exactly one engine at a time using round-robin.
- Locks the grant until the engine reports done or a watchdog expires.
- Routes the granted engine's read-FIFO pointer/ready and write-FIFO request/data/strobe, with per-operation beat counters and protocol-error flags.

Parameters:
NUM_ENG, 3, number of engines (index 0=compressor, 1=decompressor, 2=migrator by convention); range 2..8
DATA_W, `HACD_AXI4_DATA_WIDTH, write data width
STRB_W, `HACD_AXI4_STRB_WIDTH, write strobe width
PTR_W, `FIFO_PTR_WIDTH, read-FIFO pointer width
CNT_W, 8, beat counter width
TIMEOUT, 4096, max ACTIVE cycles before abort; 0 disables the watchdog

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
req_start_i  in  NUM_ENG  level op request per engine; held until op_done_o
eng_start_o  out  NUM_ENG  one-hot start to the granted engine
eng_done_i  in  NUM_ENG  engine done (level or pulse)
op_done_o  out  NUM_ENG  one-cycle completion pulse to the requester
eng_rd_req_i  in  NUM_ENG  engine read request
eng_ld_rdptr_i  in  NUM_ENG  engine read-pointer load strobe
eng_rdptr_i  in  NUM_ENG*PTR_W  packed engine read pointers
eng_wr_req_i  in  NUM_ENG  engine write request
eng_wr_data_i  in  NUM_ENG*DATA_W  packed write data
eng_wr_strb_i  in  NUM_ENG*STRB_W  packed write strobes
rdfifo_empty_i  in  1  read FIFO empty
rd_valid_i  in  1  read data valid
wrfifo_full_i  in  1  write FIFO full
rready_o  out  1  read-FIFO pop
ld_rdptr_o  out  1  read-pointer load
rdptr_o  out  PTR_W  read-pointer value
wr_req_o  out  1  write-FIFO push
wr_data_o  out  DATA_W  write data
wr_strb_o  out  STRB_W  write strobe
grant_id_o  out  3  index of the granted engine (valid when busy_o)
busy_o  out  1  FSM is in ACTIVE or DONE
timeout_o  out  1  one-cycle pulse on watchdog abort
proto_err_o  out  1  sticky: a non-granted engine asserted rd_req/wr_req/ld_rdptr
rd_beats_o  out  CNT_W  rd_valid_i&rready_o count for the current/last op, saturating
wr_beats_o  out  CNT_W  wr_req_o count for the current/last op, saturating

Behaviour:
- Reset (rst_ni=0 at a clock edge) clears all registered state and outputs:
  - state=IDLE; eng_start_o, op_done_o, timeout_o, proto_err_o, beat counters=0.
  - RR pointer=0; grant_id_o=0.
  - Reset mid-operation aborts immediately; no op_done_o is generated.
- FSM states:
  - IDLE:
    - If any req_start_i bit is set, pick the first set bit at or after rr_ptr, wrapping modulo NUM_ENG.
    - Register grant_id; set eng_start_o[g]; clear beat and watchdog counters; go to ACTIVE.
    - Grant-to-start latency: 1 cycle after the request is sampled.
  - ACTIVE:
    - eng_start_o[g] is held high.
    - When eng_done_i[g]=1: drop eng_start_o next cycle, pulse op_done_o[g], go to DONE.
    - Watchdog: count cycles in ACTIVE; when the count reaches TIMEOUT (TIMEOUT≠0), drop start, pulse timeout_o and op_done_o[g], go to DONE.
    - If done and timeout occur in the same cycle, done wins; timeout_o stays 0.
  - DONE: one cycle; rr_ptr=(g+1) mod NUM_ENG; go to IDLE. This guarantees at least 1 idle cycle between ops, so engines see start deasserted.
- Requests:
  - Deassertion of req_start_i[g] during ACTIVE is ignored; the grant stays locked.
  - eng_done_i from non-granted engines is ignored.
- Routing (combinational from the registered grant; zero latency; all outputs are 0 unless state=ACTIVE):
  - rready_o = eng_rd_req_i[g] & ~rdfifo_empty_i
  - ld_rdptr_o = eng_ld_rdptr_i[g]
  - rdptr_o = slice g of eng_rdptr_i
  - wr_req_o = eng_wr_req_i[g] & ~wrfifo_full_i
  - wr_data_o / wr_strb_o = slice g of their inputs when wr_req_o=1, else 0
- proto_err_o:
  - Set if any non-granted engine (or any engine in IDLE) asserts rd_req, wr_req or ld_rdptr.
  - Sticky until reset.
- Beat counters:
  - Cleared on grant; increment per qualifying cycle during ACTIVE.
  - Saturate at 2^CNT_W-1; hold their value after the op until the next grant.
- The full buffer does not block done; the engine is responsible for draining.

Test Plan:
- Single request: req_start_i=3'b010 → eng_start_o=3'b010 one cycle later; engine does 4 reads and 4 writes, then done → op_done_o=3'b010 pulse for 1 cycle; rd_beats_o=4, wr_beats_o=4; busy_o returns to 0.
- Round-robin: req_start_i=3'b111 held → grant order 0,1,2,0; each eng_start_o is one-hot with ≥1 zero cycle between grants.
- Backpressure: wrfifo_full_i=1 while the granted engine holds wr_req → wr_req_o=0 and wr_beats_o unchanged; releasing full gives wr_req_o=1 the same cycle. Same check for rdfifo_empty_i against rready_o.
- Watchdog, TIMEOUT=16, engine never done:
  - Cycle 16 of ACTIVE → timeout_o=1 and op_done_o[g]=1 for 1 cycle; eng_start_o drops.
  - Same-cycle done+timeout → timeout_o stays 0.
- Isolation: a non-granted engine asserts wr_req with data 0xDEAD → wr_req_o=0, wr_data_o unaffected, proto_err_o=1 and stays 1 until reset.
- Reset mid-op: rst_ni=0 during ACTIVE → next edge all outputs 0, no op_done_o. After release with req_start_i=3'b100, engine 2 is granted (rr_ptr=0, first set bit scanning from 0).

Source files
------------

// File: rtl/hawk_compdecomp_arb.sv
// Round-robin arbiter/router that lends the shared read/write FIFO ports to one
// compression-path engine at a time, with grant lock, watchdog and beat counters.
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 64
`endif
`ifndef HACD_AXI4_STRB_WIDTH
`define HACD_AXI4_STRB_WIDTH 8
`endif
`ifndef FIFO_PTR_WIDTH
`define FIFO_PTR_WIDTH 4
`endif

module hawk_compdecomp_arb #(
   parameter int NUM_ENG = 3,
   parameter int DATA_W  = `HACD_AXI4_DATA_WIDTH,
   parameter int STRB_W  = `HACD_AXI4_STRB_WIDTH,
   parameter int PTR_W   = `FIFO_PTR_WIDTH,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_ENG-1:0]        req_start_i,
   output logic [NUM_ENG-1:0]        eng_start_o,
   input  logic [NUM_ENG-1:0]        eng_done_i,
   output logic [NUM_ENG-1:0]        op_done_o,
   input  logic [NUM_ENG-1:0]        eng_rd_req_i,
   input  logic [NUM_ENG-1:0]        eng_ld_rdptr_i,
   input  logic [NUM_ENG*PTR_W-1:0]  eng_rdptr_i,
   input  logic [NUM_ENG-1:0]        eng_wr_req_i,
   input  logic [NUM_ENG*DATA_W-1:0] eng_wr_data_i,
   input  logic [NUM_ENG*STRB_W-1:0] eng_wr_strb_i,
   input  logic                      rdfifo_empty_i,
   input  logic                      rd_valid_i,
   input  logic                      wrfifo_full_i,
   output logic                      rready_o,
   output logic                      ld_rdptr_o,
   output logic [PTR_W-1:0]          rdptr_o,
   output logic                      wr_req_o,
   output logic [DATA_W-1:0]         wr_data_o,
   output logic [STRB_W-1:0]         wr_strb_o,
   output logic [2:0]                grant_id_o,
   output logic                      busy_o,
   output logic                      timeout_o,
   output logic                      proto_err_o,
   output logic [CNT_W-1:0]          rd_beats_o,
   output logic [CNT_W-1:0]          wr_beats_o
);

   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit WD_EN = (TIMEOUT != 0);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t               state_r, state_s;
   logic [2:0]           grant_r, grant_s, rr_ptr_r, rr_ptr_s, pick_s;
   logic [NUM_ENG-1:0]   start_r, start_s, op_done_r, op_done_s;
   logic [NUM_ENG-1:0]   gnt_oh_s, own_s, rot_s;
   logic [2*NUM_ENG-1:0] dbl_s;
   logic                 timeout_r, timeout_s, proto_err_r, proto_err_s;
   logic [CNT_W-1:0]     rd_beats_r, rd_beats_s, wr_beats_r, wr_beats_s;
   logic [WD_W-1:0]      wd_cnt_r, wd_cnt_s;
   logic                 active_s, pick_vld_s, stray_s, done_hit_s, wd_exp_s;
   logic [PTR_W-1:0]     rdptr_s;
   logic [DATA_W-1:0]    wdata_s;
   logic [STRB_W-1:0]    wstrb_s;

   function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int off);
      logic [3:0] sum;
      sum = {1'b0, base} + 4'(off);
      if (sum >= 4'(NUM_ENG)) begin
         sum = sum - 4'(NUM_ENG);
      end else begin
         sum = sum;
      end
      return sum[2:0];
   endfunction

   function automatic logic [NUM_ENG-1:0] onehot(input logic [2:0] id);
      return {{(NUM_ENG-1){1'b0}}, 1'b1} << id;
   endfunction

   assign active_s   = (state_r == ST_ACTIVE);
   assign gnt_oh_s   = onehot(grant_r);
   assign own_s      = (state_r == ST_IDLE) ? {NUM_ENG{1'b0}} : gnt_oh_s;
   assign stray_s    = |((eng_rd_req_i | eng_wr_req_i | eng_ld_rdptr_i) & ~own_s);
   assign done_hit_s = |(eng_done_i & gnt_oh_s);
   assign wd_exp_s   = WD_EN && (wd_cnt_r == WD_LAST);
   // Rotating the request vector by rr_ptr turns round-robin into a lowest-index search.
   assign dbl_s      = {req_start_i, req_start_i} >> rr_ptr_r;
   assign rot_s      = dbl_s[NUM_ENG-1:0];

   // Round-robin pick: descending scan so the lowest rotated index wins last.
   always_comb begin
      pick_s     = 3'd0;
      pick_vld_s = 1'b0;
      for (int i = NUM_ENG - 1; i >= 0; i--) begin
         pick_s     = rot_s[i] ? wrap_idx(rr_ptr_r, i) : pick_s;
         pick_vld_s = pick_vld_s | rot_s[i];
      end
   end

   // Select the granted engine's slices of the packed buses.
   always_comb begin
      rdptr_s = {PTR_W{1'b0}};
      wdata_s = {DATA_W{1'b0}};
      wstrb_s = {STRB_W{1'b0}};
      for (int i = 0; i < NUM_ENG; i++) begin
         rdptr_s = rdptr_s | (eng_rdptr_i[i*PTR_W +: PTR_W] & {PTR_W{gnt_oh_s[i]}});
         wdata_s = wdata_s | (eng_wr_data_i[i*DATA_W +: DATA_W] & {DATA_W{gnt_oh_s[i]}});
         wstrb_s = wstrb_s | (eng_wr_strb_i[i*STRB_W +: STRB_W] & {STRB_W{gnt_oh_s[i]}});
      end
   end

   assign rready_o   = active_s & (|(eng_rd_req_i & gnt_oh_s)) & ~rdfifo_empty_i;
   assign ld_rdptr_o = active_s & (|(eng_ld_rdptr_i & gnt_oh_s));
   assign rdptr_o    = rdptr_s & {PTR_W{active_s}};
   assign wr_req_o   = active_s & (|(eng_wr_req_i & gnt_oh_s)) & ~wrfifo_full_i;
   assign wr_data_o  = wdata_s & {DATA_W{wr_req_o}};
   assign wr_strb_o  = wstrb_s & {STRB_W{wr_req_o}};

   // Next-state and next-register values for the grant FSM.
   always_comb begin
      state_s     = state_r;
      grant_s     = grant_r;
      rr_ptr_s    = rr_ptr_r;
      start_s     = start_r;
      op_done_s   = {NUM_ENG{1'b0}};
      timeout_s   = 1'b0;
      proto_err_s = proto_err_r | stray_s;
      rd_beats_s  = rd_beats_r;
      wr_beats_s  = wr_beats_r;
      wd_cnt_s    = wd_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (pick_vld_s) begin
               state_s    = ST_ACTIVE;
               grant_s    = pick_s;
               start_s    = onehot(pick_s);
               rd_beats_s = {CNT_W{1'b0}};
               wr_beats_s = {CNT_W{1'b0}};
               wd_cnt_s   = {WD_W{1'b0}};
            end else begin
               start_s = {NUM_ENG{1'b0}};
            end
         end
         ST_ACTIVE: begin
            rd_beats_s = (rready_o && rd_valid_i && (rd_beats_r != {CNT_W{1'b1}}))
                         ? rd_beats_r + CNT_W'(1) : rd_beats_r;
            wr_beats_s = (wr_req_o && (wr_beats_r != {CNT_W{1'b1}}))
                         ? wr_beats_r + CNT_W'(1) : wr_beats_r;
            wd_cnt_s   = wd_cnt_r + WD_W'(1);
            // Done has priority over a watchdog expiry in the same cycle.
            if (done_hit_s) begin
               state_s   = ST_DONE;
               start_s   = {NUM_ENG{1'b0}};
               op_done_s = gnt_oh_s;
            end else if (wd_exp_s) begin
               state_s   = ST_DONE;
               start_s   = {NUM_ENG{1'b0}};
               op_done_s = gnt_oh_s;
               timeout_s = 1'b1;
            end else begin
               state_s = ST_ACTIVE;
            end
         end
         ST_DONE: begin
            state_s  = ST_IDLE;
            start_s  = {NUM_ENG{1'b0}};
            rr_ptr_s = wrap_idx(grant_r, 1);
         end
         default: begin
            state_s = ST_IDLE;
            start_s = {NUM_ENG{1'b0}};
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_r     <= ST_IDLE;
         grant_r     <= 3'd0;
         rr_ptr_r    <= 3'd0;
         start_r     <= {NUM_ENG{1'b0}};
         op_done_r   <= {NUM_ENG{1'b0}};
         timeout_r   <= 1'b0;
         proto_err_r <= 1'b0;
         rd_beats_r  <= {CNT_W{1'b0}};
         wr_beats_r  <= {CNT_W{1'b0}};
         wd_cnt_r    <= {WD_W{1'b0}};
      end else begin
         state_r     <= state_s;
         grant_r     <= grant_s;
         rr_ptr_r    <= rr_ptr_s;
         start_r     <= start_s;
         op_done_r   <= op_done_s;
         timeout_r   <= timeout_s;
         proto_err_r <= proto_err_s;
         rd_beats_r  <= rd_beats_s;
         wr_beats_r  <= wr_beats_s;
         wd_cnt_r    <= wd_cnt_s;
      end
   end

   assign eng_start_o = start_r;
   assign op_done_o   = op_done_r;
   assign timeout_o   = timeout_r;
   assign proto_err_o = proto_err_r;
   assign rd_beats_o  = rd_beats_r;
   assign wr_beats_o  = wr_beats_r;
   assign grant_id_o  = grant_r;
   assign busy_o      = (state_r == ST_ACTIVE) || (state_r == ST_DONE);

endmodule
